// File: rtl/peak_frame_reader.sv
// -----------------------------------------------------------------------------
// peak_frame_reader
//
// Read-side consumer of the spectral peak finder. Each peak frame (PEAKS
// amplitude/frequency pairs plus the frame time counter) is captured whole into
// a small frame FIFO. The HPS then drains it over an Avalon-MM slave, one
// 32-bit word per read of the data address.
//
// Optional feature (compile-time macro): PEAK_READER_TIMESTAMP_EN
//   When defined, a free-running 32-bit CLOCK_50 cycle counter is latched at
//   capture time and stored as word 1 of the frame. The peak words then move to
//   words 2..PEAKS+1. When undefined, there is no cycle counter and a frame is
//   PEAKS+1 words long.
//
// Ports
//   CLOCK_50       in   1              system clock
//   reset          in   1              asynchronous, active-high
//   valid_in       in   1              frame strobe, asynchronous to CLOCK_50
//   amplitudes_in  in   AMPL_W*PEAKS   signed amplitudes, peak k at [k*AMPL_W +: AMPL_W]
//   freqs_in       in   FREQ_W*PEAKS   unsigned frequency indices, same layout
//   counter_in     in   TIME_W         frame time counter
//   chipselect     in   1              Avalon slave select
//   read           in   1              Avalon read strobe
//   write          in   1              Avalon write strobe
//   address        in   2              word address
//   writedata      in   32             write data
//   readdata       out  32             registered read data, read latency 1
//   irq            out  1              high while the FIFO holds at least one frame
//
// Avalon handshake: there is no waitrequest. A read or write is a single-cycle
// strobe qualified by chipselect, and it is always accepted in the cycle it is
// presented. Read data appears on readdata one cycle after the read strobe and
// holds until the next read.
//
// Address map
//   0 R  status: [7:0] frames stored, [8] empty, [9] full, [10] overflow,
//                [15:11] 0, [23:16] drop count, [31:24] word index
//   1 R  data stream: head frame word[index]; the last word pops the frame
//   2 W  [0] flush FIFO, [1] clear overflow and drop count
//   3    reserved: reads return 0, writes ignored
// -----------------------------------------------------------------------------
module peak_frame_reader #(
    parameter int PEAKS  = 6,
    parameter int AMPL_W = 16,
    parameter int FREQ_W = 9,
    parameter int TIME_W = 16,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic [AMPL_W*PEAKS-1:0]   amplitudes_in,
    input  logic [FREQ_W*PEAKS-1:0]   freqs_in,
    input  logic [TIME_W-1:0]         counter_in,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [1:0]                address,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic                      irq
);

    // -------------------------------------------------------------------------
    // Frame geometry
    // -------------------------------------------------------------------------
`ifdef PEAK_READER_TIMESTAMP_EN
    localparam int W         = PEAKS + 2;
    localparam int PEAK_BASE = 2;
`else
    localparam int W         = PEAKS + 1;
    localparam int PEAK_BASE = 1;
`endif

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    // Peak word: frequency zero-extended in the upper half, amplitude
    // sign-extended in the lower half.
    function automatic logic [31:0] peak_word(input logic [FREQ_W-1:0] f,
                                              input logic [AMPL_W-1:0] a);
        return {16'(f), 16'(signed'(a))};
    endfunction

    // -------------------------------------------------------------------------
    // valid_in synchroniser and rising-edge detect.
    // sync3 is the previous synchronised value, used only for edge detection.
    // -------------------------------------------------------------------------
    logic sync1_q, sync2_q, sync3_q;
    logic sync1_d, sync2_d, sync3_d;
    logic valid_rise;

    always_comb begin
        sync1_d    = valid_in;
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        valid_rise = sync2_q & ~sync3_q;
    end

    // -------------------------------------------------------------------------
    // Settle countdown. A detected rise arms the counter; the frame is written
    // SETTLE cycles after the rise was detected. Rises seen while armed are
    // ignored so a bouncing strobe cannot push the capture point out.
    // -------------------------------------------------------------------------
    logic             settle_busy_q, settle_busy_d;
    logic [SET_W-1:0] settle_cnt_q,  settle_cnt_d;
    logic             capture_fire;

    always_comb begin
        settle_busy_d = settle_busy_q;
        settle_cnt_d  = settle_cnt_q;
        capture_fire  = 1'b0;
        if (settle_busy_q) begin
            if (settle_cnt_q == '0) begin
                capture_fire  = 1'b1;
                settle_busy_d = 1'b0;
            end else begin
                settle_cnt_d = settle_cnt_q - SET_W'(1);
            end
        end else if (valid_rise) begin
            settle_busy_d = 1'b1;
            settle_cnt_d  = SETTLE_LOAD;
        end
    end

    // -------------------------------------------------------------------------
    // Optional cycle counter
    // -------------------------------------------------------------------------
`ifdef PEAK_READER_TIMESTAMP_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Incoming frame, formatted as the words the HPS will read.
    // -------------------------------------------------------------------------
    logic [31:0] frame_w [W];

    always_comb begin
        for (int i = 0; i < W; i++) begin
            frame_w[i] = '0;
        end
        frame_w[0] = 32'(counter_in);
`ifdef PEAK_READER_TIMESTAMP_EN
        frame_w[1] = cycle_cnt_q;
`endif
        for (int k = 0; k < PEAKS; k++) begin
            frame_w[PEAK_BASE + k] = peak_word(freqs_in[k*FREQ_W +: FREQ_W],
                                               amplitudes_in[k*AMPL_W +: AMPL_W]);
        end
    end

    // -------------------------------------------------------------------------
    // Frame storage. Each slot holds one complete frame; a slot is written only
    // when it is pushed, so a queued frame never follows later input changes.
    // -------------------------------------------------------------------------
    logic [31:0]      mem_q [DEPTH][W];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [IDX_W-1:0] index_q,  index_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [31:0]      readdata_q, readdata_d;

    logic        fifo_empty, fifo_full;
    logic        cs_rd, cs_wr, data_rd;
    logic        flush, clear_err;
    logic        last_pop, push_en, drop;
    logic [31:0] head_word;
    logic [31:0] status_word;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        cs_rd      = chipselect & read;
        cs_wr      = chipselect & write;
        data_rd    = cs_rd && (address == ADDR_DATA);
        flush      = cs_wr && (address == ADDR_CTRL) && writedata[0];
        clear_err  = cs_wr && (address == ADDR_CTRL) && writedata[1];
        last_pop   = data_rd && !fifo_empty && (index_q == LAST_IDX);
        head_word  = mem_q[rd_ptr_q][index_q];

        status_word = {8'(index_q), drop_cnt_q, 5'b0, overflow_q,
                       fifo_full, fifo_empty, 8'(count_q)};
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        index_d    = index_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        push_en    = 1'b0;
        drop       = 1'b0;

        if (flush) begin
            // Flush takes priority over everything, including a frame that
            // completes its settle window in the same cycle: that frame is
            // simply discarded and is not a drop.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            index_d  = '0;
        end else begin
            if (data_rd && !fifo_empty) begin
                index_d = (index_q == LAST_IDX) ? '0 : index_q + IDX_W'(1);
            end
            if (last_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // A pop in the same cycle frees a slot, so a full FIFO can still
            // accept the frame.
            push_en = capture_fire && (!fifo_full || last_pop);
            drop    = capture_fire && fifo_full && !last_pop;
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({push_en, last_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Clear is applied first so a drop in the same cycle is still recorded.
        if (clear_err) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != 8'hFF) begin
                drop_cnt_d = drop_cnt_d + 8'd1;
            end
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (cs_rd) begin
            case (address)
                ADDR_STATUS: readdata_d = status_word;
                ADDR_DATA:   readdata_d = fifo_empty ? 32'd0 : head_word;
                default:     readdata_d = 32'd0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            settle_busy_q <= 1'b0;
            settle_cnt_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            index_q       <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
            readdata_q    <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            settle_busy_q <= settle_busy_d;
            settle_cnt_q  <= settle_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            index_q       <= index_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
            readdata_q    <= readdata_d;
        end
    end

    // Frame payload needs no reset: the occupancy count says which slots hold
    // valid frames.
    always_ff @(posedge CLOCK_50) begin
        if (push_en) begin
            for (int i = 0; i < W; i++) begin
                mem_q[wr_ptr_q][i] <= frame_w[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign readdata = readdata_q;
    assign irq      = ~fifo_empty;

    // Only the two control bits of writedata carry meaning.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:2];

endmodule

// File: tb/tb_peak_frame_reader.sv
module tb_peak_frame_reader;

    localparam int PEAKS  = 6;
    localparam int AMPL_W = 16;
    localparam int FREQ_W = 9;
    localparam int TIME_W = 16;
    localparam int DEPTH  = 8;
    localparam int SETTLE = 2;

`ifdef PEAK_READER_TIMESTAMP_EN
    localparam int W   = PEAKS + 2;
    localparam int PK0 = 2;
`else
    localparam int W   = PEAKS + 1;
    localparam int PK0 = 1;
`endif

    // ---------------------------------------------------------------------
    // Clock / reset and DUT
    // ---------------------------------------------------------------------
    logic                    clk;
    logic                    reset;
    logic                    valid_in;
    logic [AMPL_W*PEAKS-1:0] amplitudes_in;
    logic [FREQ_W*PEAKS-1:0] freqs_in;
    logic [TIME_W-1:0]       counter_in;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [1:0]              address;
    logic [31:0]             writedata;
    logic [31:0]             readdata;
    logic                    irq;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    peak_frame_reader #(
        .PEAKS(PEAKS), .AMPL_W(AMPL_W), .FREQ_W(FREQ_W),
        .TIME_W(TIME_W), .DEPTH(DEPTH), .SETTLE(SETTLE)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .valid_in(valid_in),
        .amplitudes_in(amplitudes_in),
        .freqs_in(freqs_in),
        .counter_in(counter_in),
        .chipselect(chipselect),
        .read(read),
        .write(write),
        .address(address),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq)
    );

    // ---------------------------------------------------------------------
    // Reference model: a queue of frames held as raw input values; words are
    // formed arithmetically only when read.
    // ---------------------------------------------------------------------
    typedef struct {
        logic [TIME_W-1:0]        cnt;
        logic [FREQ_W-1:0]        f [PEAKS];
        logic signed [AMPL_W-1:0] a [PEAKS];
    } frame_t;

    typedef struct {
        frame_t      fr;
        logic [31:0] exp [PEAKS+1];
    } vec_t;

    frame_t fifo_m [$];
    int     idx_m;
    bit     ovf_m;
    int     drop_m;

    int n_tests;
    int n_fail;

    function automatic bit is_ts_word(input int idx);
`ifdef PEAK_READER_TIMESTAMP_EN
        return idx == 1;
`else
        return idx < 0;
`endif
    endfunction

    function automatic logic [31:0] exp_word(input frame_t fr, input int idx);
        int k;
        int av;
        if (idx == 0) return 32'(fr.cnt);
        if (is_ts_word(idx)) return 32'd0;
        k  = idx - PK0;
        av = int'(fr.a[k]);
        return (32'(fr.f[k]) << 16) | (32'(av) & 32'h0000FFFF);
    endfunction

    function automatic logic [31:0] model_status();
        int n;
        n = fifo_m.size();
        return (32'(idx_m) << 24) | (32'(drop_m) << 16) | (ovf_m ? 32'h400 : 32'h0) |
               ((n == DEPTH) ? 32'h200 : 32'h0) | ((n == 0) ? 32'h100 : 32'h0) | 32'(n);
    endfunction

    task automatic model_reset();
        fifo_m.delete();
        idx_m  = 0;
        ovf_m  = 1'b0;
        drop_m = 0;
    endtask

    task automatic model_capture(input frame_t fr);
        if (fifo_m.size() == DEPTH) begin
            ovf_m = 1'b1;
            if (drop_m < 255) drop_m++;
        end else begin
            fifo_m.push_back(fr);
        end
    endtask

    task automatic model_read(output logic [31:0] e, output bit skip);
        skip = 1'b0;
        e    = 32'd0;
        if (fifo_m.size() != 0) begin
            e    = exp_word(fifo_m[0], idx_m);
            skip = is_ts_word(idx_m);
            idx_m++;
            if (idx_m == W) begin
                void'(fifo_m.pop_front());
                idx_m = 0;
            end
        end
    endtask

    task automatic model_write(input logic [1:0] a, input logic [31:0] d);
        if (a == 2'd2) begin
            if (d[0]) begin
                fifo_m.delete();
                idx_m = 0;
            end
            if (d[1]) begin
                ovf_m  = 1'b0;
                drop_m = 0;
            end
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t fr;
        fr.cnt = TIME_W'($urandom);
        for (int k = 0; k < PEAKS; k++) begin
            fr.f[k] = FREQ_W'($urandom);
            fr.a[k] = AMPL_W'($urandom);
        end
        return fr;
    endfunction

    // ---------------------------------------------------------------------
    // Scoreboard check
    // ---------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic set_frame(input frame_t fr);
        counter_in = fr.cnt;
        for (int k = 0; k < PEAKS; k++) begin
            freqs_in[k*FREQ_W +: FREQ_W]      = fr.f[k];
            amplitudes_in[k*AMPL_W +: AMPL_W] = fr.a[k];
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk);
        #1;
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        d          = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 32'd0;
        model_write(a, d);
    endtask

    // Strobe valid_in and check irq just before and just after the capture
    // edge, which lands 2 + SETTLE + 1 edges after valid_in is first sampled.
    task automatic capture(input frame_t fr);
        set_frame(fr);
        @(posedge clk);
        #1 valid_in = 1'b1;
        repeat (2 + SETTLE) @(posedge clk);
        #1;
        check("irq_pre_capture", 32'(irq), 32'(fifo_m.size() != 0));
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        model_capture(fr);
        check("irq_post_capture", 32'(irq), 32'(fifo_m.size() != 0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rd_data_chk(input string name);
        logic [31:0] d;
        logic [31:0] e;
        bit          skip;
        bus_read(2'd1, d);
        model_read(e, skip);
        if (!skip) check(name, d, e);
    endtask

    task automatic st_chk(input string name);
        logic [31:0] d;
        bus_read(2'd0, d);
        check(name, d, model_status());
    endtask

    // ---------------------------------------------------------------------
    // Watchdog
    // ---------------------------------------------------------------------
    initial begin
        #5000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    vec_t vecs [3];

    initial begin
        logic [31:0] d;
        logic [31:0] e;
        bit          skip;
        frame_t      fr;
        int          r;

        n_tests = 0;
        n_fail  = 0;
        model_reset();

        // Vector table: frame inputs and hand-computed expected words
        vecs[0].fr.cnt = 16'd5;
        vecs[0].fr.f   = '{9'd10, 9'd11, 9'd12, 9'd13, 9'd14, 9'd15};
        vecs[0].fr.a   = '{16'sd0, -16'sd1, -16'sd2, -16'sd3, -16'sd4, -16'sd5};
        vecs[0].exp    = '{32'h00000005, 32'h000A0000, 32'h000BFFFF, 32'h000CFFFE,
                           32'h000DFFFD, 32'h000EFFFC, 32'h000FFFFB};
        vecs[1].fr.cnt = 16'hFFFF;
        vecs[1].fr.f   = '{9'd511, 9'd0, 9'd256, 9'd1, 9'd255, 9'd128};
        vecs[1].fr.a   = '{-16'sd32768, 16'sd32767, 16'sd1, -16'sd2, 16'sd0, -16'sd256};
        vecs[1].exp    = '{32'h0000FFFF, 32'h01FF8000, 32'h00007FFF, 32'h01000001,
                           32'h0001FFFE, 32'h00FF0000, 32'h0080FF00};
        vecs[2].fr.cnt = 16'h1234;
        vecs[2].fr.f   = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6};
        vecs[2].fr.a   = '{16'sd100, -16'sd100, 16'sd1000, -16'sd1000, 16'sd0, -16'sd1};
        vecs[2].exp    = '{32'h00001234, 32'h00010064, 32'h0002FF9C, 32'h000303E8,
                           32'h0004FC18, 32'h00050000, 32'h0006FFFF};

        // Clock / reset
        reset         = 1'b1;
        valid_in      = 1'b0;
        amplitudes_in = '0;
        freqs_in      = '0;
        counter_in    = '0;
        chipselect    = 1'b0;
        read          = 1'b0;
        write         = 1'b0;
        address       = 2'd0;
        writedata     = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("reset_irq", 32'(irq), 32'd0);
        bus_read(2'd0, d);
        check("reset_status", d, 32'h00000100);
        bus_read(2'd1, d);
        check("reset_data_empty", d, 32'd0);
        bus_read(2'd0, d);
        check("empty_read_no_change", d, 32'h00000100);

        // Table-driven single frames
        for (int i = 0; i < 3; i++) begin
            capture(vecs[i].fr);
            set_frame(rand_frame());
            for (int j = 0; j < W; j++) begin
                bus_read(2'd1, d);
                model_read(e, skip);
                if (!is_ts_word(j)) begin
                    check($sformatf("vec%0d_w%0d", i, j), d,
                          (j == 0) ? vecs[i].exp[0] : vecs[i].exp[j - PK0 + 1]);
                end
            end
            check($sformatf("vec%0d_irq_after", i), 32'(irq), 32'd0);
        end

        // Ten frames into a depth-8 FIFO
        for (int i = 1; i <= 10; i++) begin
            fr     = rand_frame();
            fr.cnt = TIME_W'(i);
            capture(fr);
        end
        bus_read(2'd0, d);
        check("overflow_status", d, 32'h00020608);
        check("overflow_irq", 32'(irq), 32'd1);
        bus_read(2'd1, d);
        model_read(e, skip);
        check("overflow_first_counter", d, 32'd1);
        for (int j = 1; j < W; j++) rd_data_chk("overflow_frame1");
        st_chk("after_pop_status");

        // Refill, clear errors, then last-word pop coincident with capture
        capture(rand_frame());
        bus_write(2'd2, 32'h2);
        bus_read(2'd0, d);
        check("clear_status", d, 32'h00000208);
        for (int j = 0; j < W - 1; j++) rd_data_chk("pre_coinc");
        fr = rand_frame();
        set_frame(fr);
        @(posedge clk);
        #1 valid_in = 1'b1;
        repeat (2 + SETTLE) @(posedge clk);
        #1;
        valid_in   = 1'b0;
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 2'd1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        d          = readdata;
        model_read(e, skip);
        model_capture(fr);
        if (!skip) check("coinc_last_word", d, e);
        repeat (3) @(posedge clk);
        bus_read(2'd0, d);
        check("coinc_status", d, 32'h00000208);

        // Partial read then flush
        for (int j = 0; j < 3; j++) rd_data_chk("pre_flush");
        bus_write(2'd2, 32'h1);
        bus_read(2'd0, d);
        check("flush_status", d, 32'h00000100);
        fr = rand_frame();
        capture(fr);
        bus_read(2'd1, d);
        model_read(e, skip);
        check("post_flush_word0", d, 32'(fr.cnt));
        bus_write(2'd2, 32'h1);

        // Flush coincident with a capture on a full FIFO
        while (fifo_m.size() < DEPTH) capture(rand_frame());
        set_frame(rand_frame());
        @(posedge clk);
        #1 valid_in = 1'b1;
        repeat (2 + SETTLE) @(posedge clk);
        #1;
        valid_in   = 1'b0;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 2'd2;
        writedata  = 32'h1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 32'd0;
        model_write(2'd2, 32'h1);
        repeat (3) @(posedge clk);
        bus_read(2'd0, d);
        check("flush_capture_status", d, 32'h00000100);
        check("flush_capture_irq", 32'(irq), 32'd0);

        // Reset in the middle of reading a frame
        capture(rand_frame());
        capture(rand_frame());
        rd_data_chk("pre_reset");
        rd_data_chk("pre_reset");
        #3 reset = 1'b1;
        #3;
        check("async_reset_readdata", readdata, 32'd0);
        check("async_reset_irq", 32'(irq), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        bus_read(2'd1, d);
        check("post_reset_data", d, 32'd0);
        bus_read(2'd0, d);
        check("post_reset_status", d, 32'h00000100);

        // Drop counter saturation
        while (fifo_m.size() < DEPTH) capture(rand_frame());
        for (int i = 0; i < 257; i++) capture(rand_frame());
        bus_read(2'd0, d);
        check("drop_saturate_status", d, 32'h00FF0608);
        bus_write(2'd2, 32'h3);
        st_chk("after_flush_clear");

        // Randomized traffic against the model
        for (int op = 0; op < 300; op++) begin
            r = $urandom_range(0, 19);
            if (r < 3) begin
                capture(rand_frame());
            end else if (r < 15) begin
                rd_data_chk("rand_data");
            end else if (r < 17) begin
                st_chk("rand_status");
            end else if (r == 17) begin
                bus_write(2'd3, $urandom);
                bus_read(2'd3, d);
                check("rand_addr3", d, 32'd0);
            end else if (r == 18) begin
                if ($urandom_range(0, 2) == 0) bus_write(2'd2, 32'($urandom_range(0, 3)));
                st_chk("rand_ctrl_status");
            end else begin
                @(posedge clk);
                #1;
                check("rand_irq", 32'(irq), 32'(fifo_m.size() != 0));
            end
        end

`ifdef PEAK_READER_TIMESTAMP_EN
        // Two captures exactly 1000 cycles apart
        begin
            logic [31:0] t0;
            logic [31:0] t1;
            t0 = 32'd0;
            t1 = 32'd0;
            bus_write(2'd2, 32'h3);
            fr = rand_frame();
            set_frame(fr);
            @(posedge clk);
            #1 valid_in = 1'b1;
            repeat (3) @(posedge clk);
            #1 valid_in = 1'b0;
            repeat (997) @(posedge clk);
            #1 valid_in = 1'b1;
            repeat (3) @(posedge clk);
            #1 valid_in = 1'b0;
            repeat (6) @(posedge clk);
            model_capture(fr);
            model_capture(fr);
            for (int n = 0; n < 2; n++) begin
                for (int j = 0; j < W; j++) begin
                    bus_read(2'd1, d);
                    model_read(e, skip);
                    if (!skip) check("ts_frame", d, e);
                    else if (n == 0) t0 = d;
                    else t1 = d;
                end
            end
            check("ts_diff", t1 - t0, 32'd1000);
        end
`endif

        st_chk("final_status");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
